// File: rtl/sub27_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sub27_rr_arbiter (with helper sub27_cla_sub)
// Brief   : Round-robin arbiter sharing one 27-bit CLA subtractor (S = A - B)
//           between NREQ requesters, with a registered, backpressured response.
//           Optional macro SUB_ARB_GNT_CNT_EN adds a saturating grant counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub27_cla_sub (
    input  logic [26:0] a,
    input  logic [26:0] b,
    output logic [26:0] s,
    output logic        cout
);
    localparam int c_W    = 27;
    localparam int c_GRPS = 7;

    logic [c_W-1:0] w_g;
    logic [c_W-1:0] w_p;
    logic [c_W:0]   w_c;

    // A - B computed as A + ~B + 1; generate/propagate taken against ~B.
    assign w_g = a & ~b;
    assign w_p = a ^ ~b;

    always_comb begin
        logic [c_GRPS-1:0] v_gg;
        logic [c_GRPS-1:0] v_gp;
        logic [c_GRPS:0]   v_gc;
        v_gg = '0;
        v_gp = '1;
        v_gc = '0;
        w_c  = '0;
        for (int grp = 0; grp < c_GRPS; grp++) begin
            for (int j = 0; j < 4; j++) begin
                if (4 * grp + j < c_W) begin
                    v_gg[grp] = w_g[4*grp+j] | (w_p[4*grp+j] & v_gg[grp]);
                    v_gp[grp] = v_gp[grp] & w_p[4*grp+j];
                end
            end
        end
        v_gc[0] = 1'b1;
        for (int grp = 0; grp < c_GRPS; grp++) begin
            v_gc[grp+1] = v_gg[grp] | (v_gp[grp] & v_gc[grp]);
        end
        // In-group carries only depend on the group carry-in from the lookahead.
        for (int grp = 0; grp < c_GRPS; grp++) begin
            w_c[4*grp] = v_gc[grp];
            for (int j = 0; j < 4; j++) begin
                if (4 * grp + j < c_W) begin
                    w_c[4*grp+j+1] = w_g[4*grp+j] | (w_p[4*grp+j] & w_c[4*grp+j]);
                end
            end
        end
    end

    assign s    = w_p ^ w_c[c_W-1:0];
    assign cout = w_c[c_W];
endmodule

module sub27_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*27-1:0] req_a,
    input  logic [NREQ*27-1:0] req_b,
    output logic [NREQ-1:0]  req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [26:0]      rsp_s,
`ifdef SUB_ARB_GNT_CNT_EN
    output logic [15:0]      gnt_cnt,
`endif
    output logic             rsp_cout
);
    localparam int c_W = 27;

    logic [IDW-1:0] r_last;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [c_W-1:0] r_rsp_s;
    logic           r_rsp_cout;

    logic           w_slot_free;
    logic           w_found;
    logic [IDW-1:0] w_gnt_idx;
    logic [c_W-1:0] w_op_a;
    logic [c_W-1:0] w_op_b;
    logic [c_W-1:0] w_s;
    logic           w_cout;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Search starts just after the last winner and wraps modulo NREQ.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_last) + k) % NREQ;
            if (w_slot_free && !w_found && req_valid[v_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(v_idx);
            end
        end
    end

    assign req_ready = w_found ? (NREQ'(1) << w_gnt_idx) : '0;

    assign w_op_a = req_a[c_W*int'(w_gnt_idx) +: c_W];
    assign w_op_b = req_b[c_W*int'(w_gnt_idx) +: c_W];

    sub27_cla_sub u_sub (
        .a    (w_op_a),
        .b    (w_op_b),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= IDW'(NREQ - 1);
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_s     <= '0;
            r_rsp_cout  <= 1'b0;
        end else if (w_found) begin
            r_last      <= w_gnt_idx;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_s     <= w_s;
            r_rsp_cout  <= w_cout;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef SUB_ARB_GNT_CNT_EN
    logic [15:0] r_gnt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_cnt <= '0;
        end else if (w_found && (r_gnt_cnt != 16'hFFFF)) begin
            r_gnt_cnt <= r_gnt_cnt + 16'd1;
        end
    end

    assign gnt_cnt = r_gnt_cnt;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_s     = r_rsp_s;
    assign rsp_cout  = r_rsp_cout;
endmodule

`default_nettype wire

// File: tb/tb_sub27_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sub27_rr_arbiter
// Brief   : Directed vector table plus reset sequence for sub27_rr_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sub27_rr_arbiter;
    localparam int NREQ = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*27-1:0] req_a;
    logic [NREQ*27-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [26:0]       rsp_s;
    logic              rsp_cout;
`ifdef SUB_ARB_GNT_CNT_EN
    logic [15:0]       gnt_cnt;
`endif

    sub27_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
`ifdef SUB_ARB_GNT_CNT_EN
        .gnt_cnt   (gnt_cnt),
`endif
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [26:0] a;
        logic [26:0] b;
        logic        rr;
        logic [3:0]  rdy;
        logic        vld;
        logic [1:0]  id;
        logic [26:0] s;
        logic        co;
    } vec_t;

    localparam int c_NV = 19;
    vec_t vecs [c_NV];
    int   checks;
    int   errors;
    int   exp_cnt;

    function automatic vec_t mk(logic [3:0] rv, logic [26:0] a, logic [26:0] b, logic rr,
                                logic [3:0] rdy, logic vld, logic [1:0] id,
                                logic [26:0] s, logic co);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.rr = rr;
        v.rdy = rdy; v.vld = vld; v.id = id; v.s = s; v.co = co;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Only the requester expected to win sees the real operands; others see
    // scrambled ones so a wrong grant or operand mux shows up in rsp_s.
    task automatic drive(input vec_t v);
        req_valid = v.rv;
        rsp_ready = v.rr;
        for (int i = 0; i < NREQ; i++) begin
            if (v.rdy[i]) begin
                req_a[27*i +: 27] = v.a;
                req_b[27*i +: 27] = v.b;
            end else begin
                req_a[27*i +: 27] = v.a ^ 27'h2AAAAAA;
                req_b[27*i +: 27] = v.b ^ 27'h1555555;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        vecs[0]  = mk(4'b0001, 27'h0000005, 27'h0000003, 1'b1, 4'b0001, 1'b1, 2'd0, 27'h0000002, 1'b1);
        vecs[1]  = mk(4'b0100, 27'h0000003, 27'h0000005, 1'b1, 4'b0100, 1'b1, 2'd2, 27'h7FFFFFE, 1'b0);
        vecs[2]  = mk(4'b0001, 27'h7FFFFFF, 27'h7FFFFFF, 1'b1, 4'b0001, 1'b1, 2'd0, 27'h0000000, 1'b1);
        vecs[3]  = mk(4'b1000, 27'h0000000, 27'h7FFFFFF, 1'b1, 4'b1000, 1'b1, 2'd3, 27'h0000001, 1'b0);
        vecs[4]  = mk(4'b0000, 27'h0000000, 27'h0000000, 1'b1, 4'b0000, 1'b0, 2'd3, 27'h0000001, 1'b0);
        vecs[5]  = mk(4'b1111, 27'h0000100, 27'h0000001, 1'b1, 4'b0001, 1'b1, 2'd0, 27'h00000FF, 1'b1);
        vecs[6]  = mk(4'b1111, 27'h0002000, 27'h0001000, 1'b1, 4'b0010, 1'b1, 2'd1, 27'h0001000, 1'b1);
        vecs[7]  = mk(4'b1111, 27'h0000001, 27'h0000002, 1'b1, 4'b0100, 1'b1, 2'd2, 27'h7FFFFFF, 1'b0);
        vecs[8]  = mk(4'b1111, 27'h4000000, 27'h0000001, 1'b1, 4'b1000, 1'b1, 2'd3, 27'h3FFFFFF, 1'b1);
        vecs[9]  = mk(4'b1111, 27'h1234567, 27'h0234567, 1'b1, 4'b0001, 1'b1, 2'd0, 27'h1000000, 1'b1);
        vecs[10] = mk(4'b1111, 27'h0000010, 27'h0000010, 1'b1, 4'b0010, 1'b1, 2'd1, 27'h0000000, 1'b1);
        for (int i = 11; i < 16; i++) begin
            vecs[i] = mk(4'b1111, 27'h0000007, 27'h0000001, 1'b0, 4'b0000, 1'b1, 2'd1, 27'h0000000, 1'b1);
        end
        vecs[16] = mk(4'b1111, 27'h0ABCDEF, 27'h00000EF, 1'b1, 4'b0100, 1'b1, 2'd2, 27'h0ABCD00, 1'b1);
        vecs[17] = mk(4'b0010, 27'h0000005, 27'h0000005, 1'b0, 4'b0000, 1'b1, 2'd2, 27'h0ABCD00, 1'b1);
        vecs[18] = mk(4'b0000, 27'h0000000, 27'h0000000, 1'b1, 4'b0000, 1'b0, 2'd2, 27'h0ABCD00, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_s",     32'(rsp_s),     32'd0);
        chk("reset_rsp_cout",  32'(rsp_cout),  32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
`ifdef SUB_ARB_GNT_CNT_EN
        chk("reset_gnt_cnt",   32'(gnt_cnt),   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < c_NV; n++) begin
            @(negedge clk);
            drive(vecs[n]);
            #1;
            chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(vecs[n].rdy));
            @(posedge clk);
            #1;
            if (vecs[n].rdy != 4'b0000) exp_cnt++;
            chk($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid), 32'(vecs[n].vld));
            chk($sformatf("v%0d_rsp_id", n),    32'(rsp_id),    32'(vecs[n].id));
            chk($sformatf("v%0d_rsp_s", n),     32'(rsp_s),     32'(vecs[n].s));
            chk($sformatf("v%0d_rsp_cout", n),  32'(rsp_cout),  32'(vecs[n].co));
        end

        // Mid-operation reset: build a pending response, then assert rst_n between edges.
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_a[27*1 +: 27] = 27'h0000100;
        req_b[27*1 +: 27] = 27'h0000080;
        #1;
        chk("pre_rst_req_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_rsp_s",     32'(rsp_s),     32'h80);
`ifdef SUB_ARB_GNT_CNT_EN
        chk("pre_rst_gnt_cnt",   32'(gnt_cnt),   32'(exp_cnt));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_rsp_s",     32'(rsp_s),     32'd0);
`ifdef SUB_ARB_GNT_CNT_EN
        chk("async_rst_gnt_cnt",   32'(gnt_cnt),   32'd0);
`endif

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        req_a[27*3 +: 27] = 27'h7000000;
        req_b[27*3 +: 27] = 27'h1000000;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("post_rst_rsp_id",    32'(rsp_id),    32'd1);
        chk("post_rst_rsp_s",     32'(rsp_s),     32'h80);
        @(negedge clk);
        #1;
        chk("post_rst2_req_ready", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("post_rst2_rsp_id",   32'(rsp_id),    32'd3);
        chk("post_rst2_rsp_s",    32'(rsp_s),     32'h6000000);
        chk("post_rst2_rsp_cout", 32'(rsp_cout),  32'd1);
`ifdef SUB_ARB_GNT_CNT_EN
        chk("post_rst2_gnt_cnt",  32'(gnt_cnt),   32'd2);
`endif

        @(negedge clk);
        req_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
